// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: CCE GPR indices, GPR file sizing and the writeback pipeline entry type.
package bp_cce_pkg;

    localparam int num_cce_gpr_gp       = 8;
    localparam int cce_gpr_width_gp     = 64;
    localparam int cce_gpr_sel_width_gp = $clog2(num_cce_gpr_gp);

    typedef enum logic [cce_gpr_sel_width_gp-1:0] {
        e_gpr_r0 = 3'd0,
        e_gpr_r1 = 3'd1,
        e_gpr_r2 = 3'd2,
        e_gpr_r3 = 3'd3,
        e_gpr_r4 = 3'd4,
        e_gpr_r5 = 3'd5,
        e_gpr_r6 = 3'd6,
        e_gpr_r7 = 3'd7
    } bp_cce_gpr_e;

    typedef struct packed {
        logic                            v;
        logic [cce_gpr_sel_width_gp-1:0] rd;
        logic [cce_gpr_width_gp-1:0]     data;
    } bp_cce_wb_entry_s;

endpackage

// File: rtl/bp_cce_gpr_file.sv
// bp_cce_gpr_file: num_gpr_p x width_p register file, two combinational read ports,
// one write port, asynchronous active-high reset.
module bp_cce_gpr_file #(
    parameter int width_p     = 64,
    parameter int num_gpr_p   = 8,
    parameter int sel_width_p = $clog2(num_gpr_p)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [sel_width_p-1:0]         waddr,
    input  logic [width_p-1:0]             wdata,
    input  logic [sel_width_p-1:0]         raddr_a,
    input  logic [sel_width_p-1:0]         raddr_b,
    output logic [width_p-1:0]             rdata_a,
    output logic [width_p-1:0]             rdata_b,
    output logic [num_gpr_p*width_p-1:0]   regs_flat
);

    logic [width_p-1:0] regs [num_gpr_p];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < num_gpr_p; k++)
                regs[k] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

    for (genvar i = 0; i < num_gpr_p; i++) begin : g_flat
        assign regs_flat[i*width_p +: width_p] = regs[i];
    end

endmodule

// File: rtl/bp_cce_gpr_wb.sv
// bp_cce_gpr_wb: CCE GPR operand fetch plus one-entry writeback pipeline and result flags.
// BP_CCE_GPR_BYPASS_EN forwards the pending entry to the read ports; otherwise hazard_o flags RAW.
module bp_cce_gpr_wb
    import bp_cce_pkg::*;
#(
    parameter int width_p         = cce_gpr_width_gp,
    parameter int num_gpr_p       = num_cce_gpr_gp,
    parameter int gpr_sel_width_p = $clog2(num_gpr_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [gpr_sel_width_p-1:0]     rs_a_i,
    input  logic [gpr_sel_width_p-1:0]     rs_b_i,
    output logic [width_p-1:0]             opd_a_o,
    output logic [width_p-1:0]             opd_b_o,
    input  logic                           wb_v_i,
    input  logic [gpr_sel_width_p-1:0]     wb_rd_i,
    input  logic [width_p-1:0]             wb_data_i,
    input  logic                           stall_i,
    output logic                           hazard_o,
    output logic                           zero_o,
    output logic                           neg_o,
    output logic [num_gpr_p*width_p-1:0]   gpr_o
);

    bp_cce_wb_entry_s   p_r;
    logic [width_p-1:0] rdata_a, rdata_b;
    logic               commit, match_a, match_b;

    assign commit  = p_r.v & ~stall_i;
    assign match_a = p_r.v && (p_r.rd == rs_a_i);
    assign match_b = p_r.v && (p_r.rd == rs_b_i);

    // Capture and commit share the edge: the new entry replaces the one being retired.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            p_r    <= '0;
            zero_o <= 1'b0;
            neg_o  <= 1'b0;
        end else if (!stall_i) begin
            p_r <= '{v: wb_v_i, rd: wb_rd_i, data: wb_data_i};
            if (p_r.v) begin
                zero_o <= (p_r.data == '0);
                neg_o  <= p_r.data[width_p-1];
            end
        end
    end

    bp_cce_gpr_file #(
        .width_p     (width_p),
        .num_gpr_p   (num_gpr_p),
        .sel_width_p (gpr_sel_width_p)
    ) gpr_file (
        .clk       (clk_i),
        .rst       (reset_i),
        .we        (commit),
        .waddr     (p_r.rd),
        .wdata     (p_r.data),
        .raddr_a   (rs_a_i),
        .raddr_b   (rs_b_i),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .regs_flat (gpr_o)
    );

`ifdef BP_CCE_GPR_BYPASS_EN
    always_comb begin
        opd_a_o  = match_a ? p_r.data : rdata_a;
        opd_b_o  = match_b ? p_r.data : rdata_b;
        hazard_o = 1'b0;
    end
`else
    always_comb begin
        opd_a_o  = rdata_a;
        opd_b_o  = rdata_b;
        hazard_o = match_a | match_b;
    end
`endif

endmodule

// File: tb/tb_bp_cce_gpr_wb.sv
// tb_bp_cce_gpr_wb: directed vectors for bp_cce_gpr_wb; expectations follow BP_CCE_GPR_BYPASS_EN.
module tb_bp_cce_gpr_wb;

    localparam int w = 64;
    localparam int n = 8;
    localparam int s = 3;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [s-1:0]     rs_a_i = '0, rs_b_i = '0, wb_rd_i = '0;
    logic [w-1:0]     opd_a_o, opd_b_o, wb_data_i = '0;
    logic             wb_v_i = 1'b0, stall_i = 1'b0;
    logic             hazard_o, zero_o, neg_o;
    logic [n*w-1:0]   gpr_o;

    int n_cmp = 0;
    int n_bad = 0;

    bp_cce_gpr_wb dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rs_a_i    (rs_a_i),
        .rs_b_i    (rs_b_i),
        .opd_a_o   (opd_a_o),
        .opd_b_o   (opd_b_o),
        .wb_v_i    (wb_v_i),
        .wb_rd_i   (wb_rd_i),
        .wb_data_i (wb_data_i),
        .stall_i   (stall_i),
        .hazard_o  (hazard_o),
        .zero_o    (zero_o),
        .neg_o     (neg_o),
        .gpr_o     (gpr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [w-1:0] got, input logic [w-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb(input logic v, input logic [s-1:0] rd, input logic [w-1:0] d);
        wb_v_i    = v;
        wb_rd_i   = rd;
        wb_data_i = d;
    endtask

    function automatic logic [w-1:0] slot(input int i);
        return gpr_o[i*w +: w];
    endfunction

    initial begin
        step();
        step();
        check("rst_gpr", gpr_o[w-1:0] | slot(7), '0);
        check("rst_zero", zero_o, 0);
        check("rst_neg", neg_o, 0);
        check("rst_hazard", hazard_o, 0);
        reset_i = 1'b0;

        // pending entry discarded by a mid-cycle reset pulse
        wb(1, 3, 64'h55);
        rs_a_i = 3;
        step();
        wb(0, 0, 0);
`ifdef BP_CCE_GPR_BYPASS_EN
        check("pre_rst_fwd", opd_a_o, 64'h55);
`else
        check("pre_rst_hazard", hazard_o, 1);
`endif
        #1 reset_i = 1'b1;
        #2 reset_i = 1'b0;
        check("rst_mid_hazard", hazard_o, 0);
        step();
        step();
        check("rst_mid_gpr3", slot(3), 0);
        check("rst_mid_opd_a", opd_a_o, 0);
        check("rst_mid_zero", zero_o, 0);

        // basic writeback, two-edge latency
        wb(1, 2, 64'h1234);
        step();
        wb(0, 0, 0);
        check("wb_lat1_gpr2", slot(2), 0);
        step();
        check("wb_gpr2", slot(2), 64'h1234);
        check("wb_zero", zero_o, 0);
        check("wb_neg", neg_o, 0);

        // zero flag
        wb(1, 6, 0);
        step();
        wb(0, 0, 0);
        step();
        check("zero_flag", zero_o, 1);
        check("zero_neg", neg_o, 0);

        // stall holds pipeline, GPRs and flags; wb inputs ignored while stalled
        wb(1, 1, 64'd7);
        step();
        stall_i = 1'b1;
        wb(1, 1, 64'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_gpr1", slot(1), 0);
            check("stall_zero", zero_o, 1);
        end
        stall_i = 1'b0;
        wb(0, 0, 0);
        step();
        check("unstall_gpr1", slot(1), 64'd7);
        check("unstall_zero", zero_o, 0);

        // negative flag and hold
        wb(1, 7, 64'h8000_0000_0000_0000);
        step();
        wb(0, 0, 0);
        step();
        check("neg_flag", neg_o, 1);
        check("neg_zero", zero_o, 0);
        step();
        step();
        check("neg_hold", neg_o, 1);

        // back-to-back writes to the same rd commit in order
        wb(1, 4, 64'd1);
        step();
        wb(1, 4, 64'd2);
        step();
        check("b2b_first", slot(4), 64'd1);
        wb(0, 0, 0);
        step();
        check("b2b_last", slot(4), 64'd2);

        // pending entry read: forwarded or flagged as hazard
        wb(1, 5, 64'h33);
        step();
        wb(0, 0, 0);
        step();
        check("old_gpr5", slot(5), 64'h33);
        wb(1, 5, 64'hA);
        rs_a_i = 5;
        rs_b_i = 5;
        step();
        wb(0, 0, 0);
`ifdef BP_CCE_GPR_BYPASS_EN
        check("byp_opd_a", opd_a_o, 64'hA);
        check("byp_opd_b", opd_b_o, 64'hA);
        check("byp_hazard", hazard_o, 0);
`else
        check("nobyp_hazard", hazard_o, 1);
        check("nobyp_opd_a", opd_a_o, 64'h33);
        check("nobyp_opd_b", opd_b_o, 64'h33);
`endif
        step();
        check("bubble_hazard", hazard_o, 0);
        check("bubble_opd_a", opd_a_o, 64'hA);
        check("bubble_opd_b", opd_b_o, 64'hA);

        // no same-cycle forwarding from wb_data_i
        rs_a_i = 0;
        rs_b_i = 2;
        wb(1, 0, 64'hFF);
        #1;
        check("no_fwd_opd_a", opd_a_o, 0);
        check("no_fwd_hazard", hazard_o, 0);
        step();
        wb(0, 0, 0);
`ifdef BP_CCE_GPR_BYPASS_EN
        check("fwd_r0", opd_a_o, 64'hFF);
`else
        check("hazard_r0", hazard_o, 1);
`endif
        check("unrelated_opd_b", opd_b_o, 64'h1234);
        step();
        check("commit_r0", opd_a_o, 64'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_cce_gpr_wb.md
Name: bp_cce_gpr_wb

Overview:
- Operand-fetch and writeback stage wrapped around the CCE ALU.
- Holds the CCE general-purpose registers and drives the ALU operand inputs from two read ports.
- Captures ALU results in a one-entry writeback pipeline register and commits them to the register file one cycle later.
- Produces registered zero/negative flags from each committed result for branch evaluation by the CCE decoder.

Parameters:
- width_p, 64, GPR and ALU datapath width in bits.
- num_gpr_p, 8, number of GPRs; must be a power of two and at least 2.
- gpr_sel_width_p, $clog2(num_gpr_p), width of a register index.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- rs_a_i  in  gpr_sel_width_p  read index for ALU operand A
- rs_b_i  in  gpr_sel_width_p  read index for ALU operand B
- opd_a_o  out  width_p  operand A to ALU
- opd_b_o  out  width_p  operand B to ALU
- wb_v_i  in  1  ALU result valid this cycle
- wb_rd_i  in  gpr_sel_width_p  destination GPR index
- wb_data_i  in  width_p  ALU result (res_o)
- stall_i  in  1  pipeline stall from CCE control
- hazard_o  out  1  read-after-write hazard on a pending entry
- zero_o  out  1  last committed result == 0
- neg_o  out  1  last committed result MSB
- gpr_o  out  num_gpr_p*width_p  flat GPR contents, for debug and directory address use

Behaviour:
- Reset (async, active-high):
  - all GPRs 0; pipeline valid pv_r=0, pipeline index prd_r=0, pipeline data pdata_r=0;
  - zero_o=0, neg_o=0, hazard_o=0.
  - Reset mid-operation discards any pending entry; it is never committed.
- Capture: on a clock edge with stall_i=0, pv_r<=wb_v_i, prd_r<=wb_rd_i, pdata_r<=wb_data_i.
- Commit: on a clock edge with stall_i=0 and pv_r=1:
  - gpr[prd_r]<=pdata_r;
  - zero_o<=(pdata_r==0); neg_o<=pdata_r[width_p-1].
  - Latency is ALU result to architectural GPR in 2 edges; flags update on the same edge as the GPR write.
- Stall: with stall_i=1, pipeline registers, GPRs and flags all hold. wb_v_i is ignored; upstream must hold it.
- Simultaneous capture and commit in the same cycle is normal pipelining: the new entry replaces the old one as the old one commits.
- Back-to-back writes to the same rd commit in order; the later write wins.
- Reads are combinational:
  - opd_x_o = (pv_r && prd_r==rs_x_i) ? pdata_r : gpr[rs_x_i], when bypass is enabled.
  - No forwarding from wb_data_i in the same cycle; the ALU feeds itself only through the pipeline register.
- hazard_o is combinational: pv_r && (prd_r==rs_a_i || prd_r==rs_b_i), only when bypass is disabled; otherwise constant 0.
- Index out of range is impossible because num_gpr_p is a power of two.
- Flags hold their value when no commit occurs.

Optional Feature:
- Macro: BP_CCE_GPR_BYPASS_EN.
- Defined: pending-entry forwarding is active as above and hazard_o is tied to 0.
- Undefined: opd_x_o = gpr[rs_x_i] only, and hazard_o flags the RAW condition. CCE control must assert stall_i... no: it must insert a bubble (wb_v_i=0 with stall_i=0) until hazard_o drops.

Decomposition:
- bp_cce_pkg gains:
  - bp_cce_gpr_e, the enumerated GPR indices;
  - constant num_cce_gpr_gp;
  - a struct bp_cce_wb_entry_s {v, rd, data} used for the pipeline register.
- One sub-module, bp_cce_gpr_file: num_gpr_p x width_p flops with 2 combinational read ports, 1 write port and async reset.
- Bypass and hazard logic stays in the top.

Test Plan:
- Reset mid-run: pending wb_v_i=1 rd=3 data=0x55, then reset_i pulsed -> gpr[3]=0, pv_r=0, zero_o=0, opd outputs 0.
- Basic writeback: wb_v_i=1 rd=2 data=0x1234 -> gpr_o slot 2 = 0x1234 after the 2nd edge; zero_o=0, neg_o=0.
- Flags: commit data=0 -> zero_o=1; commit data=0x8000_0000_0000_0000 -> neg_o=1, zero_o=0.
- Bypass on: rd=5 data=0xA captured, next cycle rs_a_i=5 -> opd_a_o=0xA before commit, hazard_o=0.
- Bypass off, same stimulus: hazard_o=1 and opd_a_o=old gpr[5]. After a bubble cycle -> hazard_o=0 and opd_a_o=0xA.
- Stall: capture rd=1 data=7, hold stall_i=1 for 3 cycles -> gpr[1] unchanged and flags hold. Commit on the first unstalled edge. Two back-to-back writes to rd=4 (1 then 2) -> gpr[4]=2.
